axi4_mst_fsm: RTL and testbench

- Single-outstanding AXI4 master engine; the initiator counterpart of the AXI4 slave FSM.
- Accepts one burst command at a time from a simple user port and drives the AW/W/B or AR/R channel sequence.
- Streams write data from the user and read data to the user through valid/ready handshakes.
- Sits between DMA/peripheral user logic and the AXI4 interconnect; bus widths come from the shared AXI4 define macros.

---
 rtl/axi4_mst_fsm.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_axi4_mst_fsm.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_mst_fsm.sv
// ---------------------------------------------------------------------------
// axi4_mst_fsm
//   Single-outstanding AXI4 master engine. A user command (write or read
//   burst) is turned into the AW/W/B or AR/R channel sequence. Write beats
//   stream from the user port onto W and read beats stream from R to the
//   user port, both as combinational pass-through.
//
//   Optional feature: define AXI4_MST_ERR_EN to enable the sticky error flag
//   usr_err_o. Without it, usr_err_o is tied low and usr_err_clr_i is ignored.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   usr_req_*            burst command handshake (wen/addr/len/size/burst)
//   usr_wdat_* / wstrb   write-data handshake from the user
//   usr_rdat_*           read-data handshake to the user (data, last flag)
//   usr_done_o           one-cycle pulse when a burst completes
//   usr_resp_o           response of the last completed burst
//   usr_err_o/_clr_i     sticky error flag and its clear
//   aw*, w*, b*, ar*, r* AXI4 master channels
// ---------------------------------------------------------------------------
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module axi4_mst_fsm #(
    parameter logic [`AXI4_ID_WIDTH-1:0] MST_ID = {`AXI4_ID_WIDTH{1'b0}}
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    // user command port
    input  logic                          usr_req_valid_i,
    output logic                          usr_req_ready_o,
    input  logic                          usr_req_wen_i,
    input  logic [`AXI4_ADDR_WIDTH-1:0]   usr_req_addr_i,
    input  logic [7:0]                    usr_req_len_i,
    input  logic [2:0]                    usr_req_size_i,
    input  logic [1:0]                    usr_req_burst_i,
    // user write data
    input  logic                          usr_wdat_valid_i,
    output logic                          usr_wdat_ready_o,
    input  logic [`AXI4_DATA_WIDTH-1:0]   usr_wdat_i,
    input  logic [`AXI4_DATA_WIDTH/8-1:0] usr_wstrb_i,
    // user read data
    output logic                          usr_rdat_valid_o,
    input  logic                          usr_rdat_ready_i,
    output logic [`AXI4_DATA_WIDTH-1:0]   usr_rdat_o,
    output logic                          usr_rdat_last_o,
    // completion / status
    output logic                          usr_done_o,
    output logic [1:0]                    usr_resp_o,
    output logic                          usr_err_o,
    input  logic                          usr_err_clr_i,
    // AW channel
    output logic [`AXI4_ID_WIDTH-1:0]     awid,
    output logic [`AXI4_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awlock,
    output logic [3:0]                    awcache,
    output logic [2:0]                    awprot,
    output logic [3:0]                    awqos,
    output logic [3:0]                    awregion,
    output logic [`AXI4_USER_WIDTH-1:0]   awuser,
    output logic                          awvalid,
    input  logic                          awready,
    // W channel
    output logic [`AXI4_DATA_WIDTH-1:0]   wdata,
    output logic [`AXI4_DATA_WIDTH/8-1:0] wstrb,
    output logic                          wlast,
    output logic [`AXI4_USER_WIDTH-1:0]   wuser,
    output logic                          wvalid,
    input  logic                          wready,
    // B channel
    input  logic [`AXI4_ID_WIDTH-1:0]     bid,
    input  logic [1:0]                    bresp,
    input  logic [`AXI4_USER_WIDTH-1:0]   buser,
    input  logic                          bvalid,
    output logic                          bready,
    // AR channel
    output logic [`AXI4_ID_WIDTH-1:0]     arid,
    output logic [`AXI4_ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arlock,
    output logic [3:0]                    arcache,
    output logic [2:0]                    arprot,
    output logic [3:0]                    arqos,
    output logic [3:0]                    arregion,
    output logic [`AXI4_USER_WIDTH-1:0]   aruser,
    output logic                          arvalid,
    input  logic                          arready,
    // R channel
    input  logic [`AXI4_ID_WIDTH-1:0]     rid,
    input  logic [`AXI4_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic [`AXI4_USER_WIDTH-1:0]   ruser,
    input  logic                          rvalid,
    output logic                          rready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic [`AXI4_ADDR_WIDTH-1:0]   addr_r;
    logic [7:0]                    len_r;
    logic [2:0]                    size_r;
    logic [1:0]                    burst_r;
    logic [7:0]                    beat_cnt_r;
    logic                          req_ready_r;
    logic                          done_r;
    logic [1:0]                    resp_r;
    logic [1:0]                    worst_r;

    logic                          req_hs_s;
    logic                          w_hs_s;
    logic                          b_hs_s;
    logic                          r_hs_s;
    logic                          last_beat_s;
    logic                          unused_s;

    // Worst-of-two AXI responses; the encodings are ordered by severity.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // ready is registered from next-state so it is low during and right after reset
    assign req_hs_s    = usr_req_valid_i & req_ready_r;
    assign w_hs_s      = (state_r == S_W) & usr_wdat_valid_i & wready;
    assign b_hs_s      = (state_r == S_B) & bvalid;
    assign r_hs_s      = (state_r == S_R) & rvalid & usr_rdat_ready_i;
    assign last_beat_s = (beat_cnt_r == len_r);

    // user-side status
    assign usr_req_ready_o  = req_ready_r;
    assign usr_done_o       = done_r;
    assign usr_resp_o       = resp_r;

    // AW channel: fields come from the latched command, stable while awvalid
    assign awid     = MST_ID;
    assign awaddr   = addr_r;
    assign awlen    = len_r;
    assign awsize   = size_r;
    assign awburst  = burst_r;
    assign awlock   = 1'b0;
    assign awcache  = 4'h0;
    assign awprot   = 3'h0;
    assign awqos    = 4'h0;
    assign awregion = 4'h0;
    assign awuser   = {`AXI4_USER_WIDTH{1'b0}};
    assign awvalid  = (state_r == S_AW);

    // W channel: user beats pass straight through, gated to the W phase
    assign wdata            = usr_wdat_i;
    assign wstrb            = usr_wstrb_i;
    assign wlast            = (state_r == S_W) & last_beat_s;
    assign wuser            = {`AXI4_USER_WIDTH{1'b0}};
    assign wvalid           = (state_r == S_W) & usr_wdat_valid_i;
    assign usr_wdat_ready_o = (state_r == S_W) & wready;

    // B channel
    assign bready = (state_r == S_B);

    // AR channel
    assign arid     = MST_ID;
    assign araddr   = addr_r;
    assign arlen    = len_r;
    assign arsize   = size_r;
    assign arburst  = burst_r;
    assign arlock   = 1'b0;
    assign arcache  = 4'h0;
    assign arprot   = 3'h0;
    assign arqos    = 4'h0;
    assign arregion = 4'h0;
    assign aruser   = {`AXI4_USER_WIDTH{1'b0}};
    assign arvalid  = (state_r == S_AR);

    // R channel: zero-latency pass-through to the user
    assign rready           = (state_r == S_R) & usr_rdat_ready_i;
    assign usr_rdat_valid_o = (state_r == S_R) & rvalid;
    assign usr_rdat_o       = rdata;
    assign usr_rdat_last_o  = rlast;

    // user sideband bits and (optionally) ids/clear are not consumed
    assign unused_s = ^{bid, rid, buser, ruser, usr_err_clr_i, 1'b0};

    // Next-state decode for the channel sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_hs_s) begin
                    state_nxt_s = usr_req_wen_i ? S_AW : S_AR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_AW: begin
                if (awready) begin
                    state_nxt_s = S_W;
                end else begin
                    state_nxt_s = S_AW;
                end
            end
            S_W: begin
                if (w_hs_s && last_beat_s) begin
                    state_nxt_s = S_B;
                end else begin
                    state_nxt_s = S_W;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_B;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_nxt_s = S_R;
                end else begin
                    state_nxt_s = S_AR;
                end
            end
            S_R: begin
                if (r_hs_s && rlast) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_R;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, latched command, beat counter and completion status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r     <= S_IDLE;
            addr_r      <= {`AXI4_ADDR_WIDTH{1'b0}};
            len_r       <= 8'd0;
            size_r      <= 3'd0;
            burst_r     <= 2'd0;
            beat_cnt_r  <= 8'd0;
            req_ready_r <= 1'b0;
            done_r      <= 1'b0;
            resp_r      <= 2'b00;
            worst_r     <= 2'b00;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == S_IDLE);
            done_r      <= 1'b0;
            if (req_hs_s) begin
                addr_r     <= usr_req_addr_i;
                len_r      <= usr_req_len_i;
                size_r     <= usr_req_size_i;
                burst_r    <= usr_req_burst_i;
                beat_cnt_r <= 8'd0;
                worst_r    <= 2'b00;
            end
            if (w_hs_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
            end
            if (b_hs_s) begin
                done_r <= 1'b1;
                resp_r <= bresp;
            end
            if (r_hs_s) begin
                beat_cnt_r <= beat_cnt_r + 8'd1;
                worst_r    <= resp_max(worst_r, rresp);
                if (rlast) begin
                    // include the final beat's response in the burst result
                    done_r <= 1'b1;
                    resp_r <= resp_max(worst_r, rresp);
                end
            end
        end
    end

`ifdef AXI4_MST_ERR_EN
    logic err_set_s;
    logic err_r;

    // Error events seen on a B or R handshake.
    always_comb begin
        err_set_s = 1'b0;
        if (b_hs_s) begin
            err_set_s = (bresp != 2'b00) || (bid != MST_ID);
        end else if (r_hs_s) begin
            err_set_s = (rresp != 2'b00) || (rlast && !last_beat_s) || (rid != MST_ID);
        end else begin
            err_set_s = 1'b0;
        end
    end

    // Sticky error flag; a new error takes priority over a clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (usr_err_clr_i) begin
            err_r <= 1'b0;
        end
    end

    assign usr_err_o = err_r;
`else
    assign usr_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_mst_fsm.sv
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 32
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 32
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif

module tb_axi4_mst_fsm;
    localparam int AW = `AXI4_ADDR_WIDTH;
    localparam int DW = `AXI4_DATA_WIDTH;
    localparam int IW = `AXI4_ID_WIDTH;
    localparam int UW = `AXI4_USER_WIDTH;
    localparam logic [IW-1:0] MST = IW'(5);

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic usr_req_valid_i, usr_req_ready_o, usr_req_wen_i;
    logic [AW-1:0] usr_req_addr_i;
    logic [7:0] usr_req_len_i;
    logic [2:0] usr_req_size_i;
    logic [1:0] usr_req_burst_i;
    logic usr_wdat_valid_i, usr_wdat_ready_o;
    logic [DW-1:0] usr_wdat_i;
    logic [DW/8-1:0] usr_wstrb_i;
    logic usr_rdat_valid_o, usr_rdat_ready_i, usr_rdat_last_o;
    logic [DW-1:0] usr_rdat_o;
    logic usr_done_o, usr_err_o, usr_err_clr_i;
    logic [1:0] usr_resp_o;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awlock, arlock, awvalid, awready, arvalid, arready;
    logic [3:0] awcache, awqos, awregion, arcache, arqos, arregion;
    logic [UW-1:0] awuser, aruser, wuser, buser, ruser;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    axi4_mst_fsm #(.MST_ID(MST)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .usr_req_valid_i(usr_req_valid_i), .usr_req_ready_o(usr_req_ready_o),
        .usr_req_wen_i(usr_req_wen_i), .usr_req_addr_i(usr_req_addr_i),
        .usr_req_len_i(usr_req_len_i), .usr_req_size_i(usr_req_size_i),
        .usr_req_burst_i(usr_req_burst_i),
        .usr_wdat_valid_i(usr_wdat_valid_i), .usr_wdat_ready_o(usr_wdat_ready_o),
        .usr_wdat_i(usr_wdat_i), .usr_wstrb_i(usr_wstrb_i),
        .usr_rdat_valid_o(usr_rdat_valid_o), .usr_rdat_ready_i(usr_rdat_ready_i),
        .usr_rdat_o(usr_rdat_o), .usr_rdat_last_o(usr_rdat_last_o),
        .usr_done_o(usr_done_o), .usr_resp_o(usr_resp_o),
        .usr_err_o(usr_err_o), .usr_err_clr_i(usr_err_clr_i),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ax_t;
    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } wb_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rb_t;

    ax_t        exp_aw[$];
    ax_t        exp_ar[$];
    wb_t        exp_w[$];
    rb_t        exp_r[$];
    logic [1:0] exp_done[$];

    int n_checks = 0;
    int n_errors = 0;

    // slave knobs
    logic          rdy_toggle = 1'b0;
    logic          r_stall    = 1'b0;
    logic [DW-1:0] r_base     = '0;
    int            r_err_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AXI slave + read-side user model; drives right after the rising edge
    initial begin : slave
        logic w_last_hs, ar_hs, r_hs, b_hs;
        logic [7:0] ar_len_s;
        int r_idx, r_n;
        logic r_active;
        r_active = 1'b0; r_idx = 0; r_n = 0;
        forever begin
            @(negedge aclk);
            w_last_hs = wvalid && wready && wlast;
            ar_hs     = arvalid && arready;
            ar_len_s  = arlen;
            r_hs      = rvalid && rready;
            b_hs      = bvalid && bready;
            @(posedge aclk); #1;
            if (!aresetn) begin
                bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; r_active = 1'b0;
            end else begin
                usr_rdat_ready_i = rdy_toggle ? ~usr_rdat_ready_i : 1'b1;
                if (b_hs) bvalid = 1'b0;
                if (w_last_hs) begin
                    bvalid = 1'b1; bresp = 2'b00; bid = MST;
                end
                if (r_hs) begin
                    r_idx++; rvalid = 1'b0;
                end
                if (ar_hs) begin
                    r_active = 1'b1; r_idx = 0; r_n = int'(ar_len_s) + 1;
                end
                if (r_active) begin
                    if (r_idx >= r_n) begin
                        r_active = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                    end else if (!rvalid) begin
                        if (!r_stall || $urandom_range(0, 1) == 1) begin
                            rvalid = 1'b1;
                            rdata  = r_base + DW'(r_idx);
                            rresp  = (r_idx == r_err_beat) ? 2'b10 : 2'b00;
                            rlast  = (r_idx == r_n - 1);
                            rid    = MST;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT presents output
    initial begin : monitor
        logic aw_pend, ar_pend, aw_ok, b_prev, rl_prev, done_prev;
        wb_t ew;
        rb_t er;
        logic [1:0] ed;
        aw_pend = 0; ar_pend = 0; aw_ok = 0; b_prev = 0; rl_prev = 0; done_prev = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_pend = 0; ar_pend = 0; aw_ok = 0; b_prev = 0; rl_prev = 0; done_prev = 0;
            end else begin
                if (aw_pend) chk("aw_held", 64'(awvalid), 64'd1);
                if (ar_pend) chk("ar_held", 64'(arvalid), 64'd1);
                if (b_prev) chk("done_after_b", 64'(usr_done_o), 64'd1);
                if (rl_prev) chk("done_after_rlast", 64'(usr_done_o), 64'd1);
                if (done_prev) chk("done_one_cycle", 64'(usr_done_o), 64'd0);
                if (awvalid) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                    else begin
                        chk("aw_fields", 64'({awaddr, awlen, awsize, awburst}), 64'(exp_aw[0]));
                        chk("awid", 64'(awid), 64'(MST));
                        if (awready) begin
                            void'(exp_aw.pop_front());
                            aw_ok = 1;
                        end
                    end
                end
                if (arvalid) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                    else begin
                        chk("ar_fields", 64'({araddr, arlen, arsize, arburst}), 64'(exp_ar[0]));
                        chk("arid", 64'(arid), 64'(MST));
                        if (arready) void'(exp_ar.pop_front());
                    end
                end
                if (wvalid) begin
                    chk("w_after_aw", 64'(aw_ok), 64'd1);
                    if (wready) begin
                        if (exp_w.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                        else begin
                            ew = exp_w.pop_front();
                            chk("wdata", 64'(wdata), 64'(ew.data));
                            chk("wstrb", 64'(wstrb), 64'(ew.strb));
                            chk("wlast", 64'(wlast), 64'(ew.last));
                            if (ew.last) aw_ok = 0;
                        end
                    end
                end
                if (usr_rdat_valid_o && usr_rdat_ready_i) begin
                    if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                    else begin
                        er = exp_r.pop_front();
                        chk("rdat", 64'(usr_rdat_o), 64'(er.data));
                        chk("rdat_last", 64'(usr_rdat_last_o), 64'(er.last));
                    end
                end
                if (usr_done_o) begin
                    if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                    else begin
                        ed = exp_done.pop_front();
                        chk("usr_resp", 64'(usr_resp_o), 64'(ed));
                    end
                end
                aw_pend   = awvalid && !awready;
                ar_pend   = arvalid && !arready;
                b_prev    = bvalid && bready;
                rl_prev   = rvalid && rready && rlast;
                done_prev = usr_done_o;
            end
        end
    end

    task automatic issue_cmd(input logic wen, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
        logic ok;
        ok = 1'b0;
        usr_req_valid_i = 1'b1; usr_req_wen_i = wen; usr_req_addr_i = addr;
        usr_req_len_i = len; usr_req_size_i = size; usr_req_burst_i = burst;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge aclk);
            if (usr_req_ready_o) ok = 1'b1;
            @(posedge aclk); #1;
        end
        usr_req_valid_i = 1'b0;
        chk("req_accepted", 64'(ok), 64'd1);
    endtask

    task automatic feed_w(input int n, input logic [DW-1:0] base);
        logic ok;
        for (int i = 0; i < n; i++) begin
            usr_wdat_i = base + DW'(i); usr_wstrb_i = '1; usr_wdat_valid_i = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge aclk);
                if (usr_wdat_ready_o) ok = 1'b1;
                @(posedge aclk); #1;
            end
            chk("wbeat_accepted", 64'(ok), 64'd1);
        end
        usr_wdat_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 800 && !seen; c++) begin
            @(negedge aclk);
            if (usr_done_o) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(posedge aclk); #1;
    endtask

    task automatic push_w(input int n, input logic [DW-1:0] base, input int last_idx);
        wb_t t;
        for (int i = 0; i < n; i++) begin
            t.data = base + DW'(i); t.strb = '1; t.last = (i == last_idx);
            exp_w.push_back(t);
        end
    endtask

    task automatic push_r(input int n, input logic [DW-1:0] base);
        rb_t t;
        for (int i = 0; i < n; i++) begin
            t.data = base + DW'(i); t.last = (i == n - 1);
            exp_r.push_back(t);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic exp_err;
        usr_req_valid_i = 0; usr_req_wen_i = 0; usr_req_addr_i = '0; usr_req_len_i = '0;
        usr_req_size_i = '0; usr_req_burst_i = '0; usr_wdat_valid_i = 0; usr_wdat_i = '0;
        usr_wstrb_i = '0; usr_rdat_ready_i = 1; usr_err_clr_i = 0;
        awready = 1; wready = 1; arready = 1;
        bid = '0; bresp = '0; buser = '0; bvalid = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; ruser = '0; rvalid = 0;
`ifdef AXI4_MST_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // reset state
        #12;
        chk("rst_req_ready", 64'(usr_req_ready_o), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_done", 64'(usr_done_o), 64'd0);
        chk("rst_resp", 64'(usr_resp_o), 64'd0);
        chk("rst_err", 64'(usr_err_o), 64'd0);
        @(posedge aclk); #1; aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("req_ready_after_reset", 64'(usr_req_ready_o), 64'd1);

        // write len 3 INCR @0x1000
        exp_aw.push_back({AW'(32'h1000), 8'd3, 3'd2, 2'd1});
        push_w(4, DW'(32'hA5A5_0000), 3);
        exp_done.push_back(2'b00);
        fork
            issue_cmd(1'b1, AW'(32'h1000), 8'd3, 3'd2, 2'd1);
            feed_w(4, DW'(32'hA5A5_0000));
        join
        wait_done();

        // read len 0 @0x20
        r_base = DW'(32'hC0DE_0000);
        exp_ar.push_back({AW'(32'h20), 8'd0, 3'd2, 2'd1});
        push_r(1, r_base);
        exp_done.push_back(2'b00);
        issue_cmd(1'b0, AW'(32'h20), 8'd0, 3'd2, 2'd1);
        wait_done();

        // read len 7 with user ready toggling and random R stalls
        r_base = DW'(32'h3000_0000); rdy_toggle = 1'b1; r_stall = 1'b1;
        exp_ar.push_back({AW'(32'h300), 8'd7, 3'd2, 2'd1});
        push_r(8, r_base);
        exp_done.push_back(2'b00);
        issue_cmd(1'b0, AW'(32'h300), 8'd7, 3'd2, 2'd1);
        wait_done();
        rdy_toggle = 1'b0; r_stall = 1'b0; usr_rdat_ready_i = 1'b1;

        // write with awready held low; user data offered early
        awready = 1'b0;
        exp_aw.push_back({AW'(32'h2000), 8'd1, 3'd2, 2'd1});
        push_w(2, DW'(32'h0BAD_F000), 1);
        exp_done.push_back(2'b00);
        fork
            issue_cmd(1'b1, AW'(32'h2000), 8'd1, 3'd2, 2'd1);
            feed_w(2, DW'(32'h0BAD_F000));
            begin
                repeat (6) @(posedge aclk);
                #1 awready = 1'b1;
            end
        join
        wait_done();

        // read len 3 with SLVERR on beat 2
        r_base = DW'(32'h4400_0000); r_err_beat = 1;
        exp_ar.push_back({AW'(32'h400), 8'd3, 3'd2, 2'd1});
        push_r(4, r_base);
        exp_done.push_back(2'b10);
        issue_cmd(1'b0, AW'(32'h400), 8'd3, 3'd2, 2'd1);
        wait_done();
        r_err_beat = -1;
        chk("err_after_slverr", 64'(usr_err_o), 64'(exp_err));
        repeat (2) @(posedge aclk);
        #1;
        chk("resp_held", 64'(usr_resp_o), 64'd2);
        usr_err_clr_i = 1'b1;
        @(posedge aclk); #1; usr_err_clr_i = 1'b0;
        chk("err_cleared", 64'(usr_err_o), 64'd0);

        // reset in the middle of the W phase
        exp_aw.push_back({AW'(32'h5000), 8'd3, 3'd2, 2'd1});
        push_w(2, DW'(32'h7700_0000), 3);
        fork
            issue_cmd(1'b1, AW'(32'h5000), 8'd3, 3'd2, 2'd1);
            feed_w(2, DW'(32'h7700_0000));
        join
        usr_wdat_i = DW'(32'h7700_0002); usr_wdat_valid_i = 1'b1;
        aresetn = 1'b0;
        #1;
        chk("midrst_wvalid", 64'(wvalid), 64'd0);
        chk("midrst_wready", 64'(usr_wdat_ready_o), 64'd0);
        chk("midrst_bready", 64'(bready), 64'd0);
        chk("midrst_req_ready", 64'(usr_req_ready_o), 64'd0);
        usr_wdat_valid_i = 1'b0;
        exp_w.delete(); exp_aw.delete();
        @(posedge aclk); #1; aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("req_ready_after_midrst", 64'(usr_req_ready_o), 64'd1);
        chk("no_done_after_midrst", 64'(usr_done_o), 64'd0);
        chk("resp_after_midrst", 64'(usr_resp_o), 64'd0);

        // full 256-beat read, counter wrap boundary
        r_base = DW'(32'h5500_0000);
        exp_ar.push_back({AW'(32'h8000), 8'd255, 3'd2, 2'd1});
        push_r(256, r_base);
        exp_done.push_back(2'b00);
        issue_cmd(1'b0, AW'(32'h8000), 8'd255, 3'd2, 2'd1);
        wait_done();

        repeat (3) @(posedge aclk);
        chk("scoreboard_drained",
            64'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size() + exp_done.size()),
            64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
